sum_seq_n: RTL

SUM_SEQ_N -- requirements
Module: sum_seq_n

---
 rtl/sum_seq_n_pkg.sv | 16 +
 rtl/sum_seq_n_if.sv | 27 ++
 rtl/sum_seq_n_chunk.sv | 33 +++
 rtl/sum_seq_n.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/sum_seq_n_pkg.sv
// sum_pkg: shared types for the sequential K-bit-per-cycle adder (sum_seq_n).
//   state_t   : FSM state encoding
//   cnt_width : chunk-counter width for P chunks (clog2 of P, at least 1 bit)
package sum_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int cnt_width(input int p);
      return (p > 1) ? $clog2(p) : 1;
   endfunction

endpackage

// File: rtl/sum_seq_n_if.sv
// sum_seq_n_if: request/result bundle for sum_seq_n.
//   master : drives start, sub, a, b; receives busy, done, y, cout, ovf, zero
//   slave  : the adder side
interface sum_seq_n_if #(
   parameter int M = 16
);
   logic         start;
   logic         sub;
   logic [M-1:0] a;
   logic [M-1:0] b;
   logic         busy;
   logic         done;
   logic [M-1:0] y;
   logic         cout;
   logic         ovf;
   logic         zero;

   modport master (
      output start, sub, a, b,
      input  busy, done, y, cout, ovf, zero
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, y, cout, ovf, zero
   );
endinterface

// File: rtl/sum_seq_n_chunk.sv
// sum_chunk: K-bit combinational ripple-carry adder slice.
//   a, b  : K-bit operands
//   cin   : carry in
//   s     : K-bit sum
//   cout  : carry out of the slice MSB
//   c_msb : carry into the slice MSB (used for overflow on the top chunk)
module sum_chunk #(
   parameter int K = 4
) (
   input  logic [K-1:0] a,
   input  logic [K-1:0] b,
   input  logic         cin,
   output logic [K-1:0] s,
   output logic         cout,
   output logic         c_msb
);

   logic [K:0] c;

   always_comb begin
      s    = '0;
      c    = '0;
      c[0] = cin;
      for (int j = 0; j < K; j++) begin
         s[j]   = a[j] ^ b[j] ^ c[j];
         c[j+1] = (a[j] & b[j]) | (c[j] & (a[j] ^ b[j]));
      end
   end

   assign cout  = c[K];
   assign c_msb = c[K-1];

endmodule

// File: rtl/sum_seq_n.sv
// sum_seq_n: sequential adder/subtractor, K bits per clock, M-bit operands.
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active low
//   bus   : sum_seq_n_if.slave (start/sub/a/b in; busy/done/y/cout/ovf/zero out)
// Optional feature: define SUM_SEQ_SAT_EN to saturate y on signed overflow;
// otherwise y wraps modulo 2^M. cout/ovf always describe the raw sum.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start
// ST_RUN  | adding one K-bit chunk per cycle, busy=1
// ST_DONE | results registered, done=1 for this single cycle
module sum_seq_n
   import sum_pkg::*;
#(
   parameter int M = 16,
   parameter int K = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   sum_seq_n_if.slave   bus
);

   localparam int P  = M / K;
   localparam int CW = cnt_width(P);

   state_t         state_q;
   logic [CW-1:0]  cnt_q;
   logic           carry_q;
   logic [M-1:0]   a_q;
   logic [M-1:0]   b_q;
   logic [M-1:0]   sum_q;

   logic           busy_q;
   logic           done_q;
   logic [M-1:0]   y_q;
   logic           cout_q;
   logic           ovf_q;
   logic           zero_q;

   logic [K-1:0]   ch_a;
   logic [K-1:0]   ch_b;
   logic [K-1:0]   ch_s;
   logic           ch_cout;
   logic           ch_cmsb;
   logic [M-1:0]   res_raw_d;
   logic [M-1:0]   res_y_d;
   logic           ovf_d;
   logic           last_chunk;

   assign ch_a = a_q[cnt_q*K +: K];
   assign ch_b = b_q[cnt_q*K +: K];

   sum_chunk #(.K(K)) u_chunk (
      .a     (ch_a),
      .b     (ch_b),
      .cin   (carry_q),
      .s     (ch_s),
      .cout  (ch_cout),
      .c_msb (ch_cmsb)
   );

   // Partial result with the current chunk merged in; on the last chunk this
   // is the complete sum.
   always_comb begin
      res_raw_d = sum_q;
      res_raw_d[cnt_q*K +: K] = ch_s;
   end

   assign ovf_d      = ch_cmsb ^ ch_cout;
   assign last_chunk = (cnt_q == CW'(P - 1));

`ifdef SUM_SEQ_SAT_EN
   // On overflow both operand MSBs are equal, so a's MSB gives the direction.
   always_comb begin
      res_y_d = res_raw_d;
      if (ovf_d) begin
         res_y_d = a_q[M-1] ? {1'b1, {(M-1){1'b0}}} : {1'b0, {(M-1){1'b1}}};
      end
   end
`else
   assign res_y_d = res_raw_d;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         y_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  a_q     <= bus.a;
                  b_q     <= bus.sub ? ~bus.b : bus.b;
                  carry_q <= bus.sub;
                  cnt_q   <= '0;
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_RUN: begin
               sum_q   <= res_raw_d;
               carry_q <= ch_cout;
               cnt_q   <= cnt_q + 1'b1;
               if (last_chunk) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  y_q     <= res_y_d;
                  cout_q  <= ch_cout;
                  ovf_q   <= ovf_d;
                  zero_q  <= (res_y_d == '0);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.y    = y_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;
   assign bus.zero = zero_q;

endmodule
